// File: rtl/ex_pkg.sv
// ex_pkg: shared widths, opcode values, memop/enable encodings and
// multiply/divide FSM states for the execute stage.
package ex_pkg;

  localparam int unsigned WORD       = 32;
  localparam int unsigned REG_ADDR   = 5;
  localparam int unsigned EX_OP_HIGH = 3;
  localparam int unsigned EX_OP_LOW  = 5;
  localparam int unsigned MEM_OP     = 2;
  localparam int unsigned CNT_W      = 5;

  // Op classes
  localparam logic [EX_OP_HIGH-1:0] EX_HIGH_SPECIAL = 3'd0;
  localparam logic [EX_OP_HIGH-1:0] EX_HIGH_LOGIC   = 3'd1;
  localparam logic [EX_OP_HIGH-1:0] EX_HIGH_ARITH   = 3'd2;
  localparam logic [EX_OP_HIGH-1:0] EX_HIGH_MEMACC  = 3'd3;
  localparam logic [EX_OP_HIGH-1:0] EX_HIGH_MULDIV  = 3'd4;

  // LOGIC ops
  localparam logic [EX_OP_LOW-1:0] EX_LOGIC_AND = 5'd0;
  localparam logic [EX_OP_LOW-1:0] EX_LOGIC_OR  = 5'd1;
  localparam logic [EX_OP_LOW-1:0] EX_LOGIC_XOR = 5'd2;
  localparam logic [EX_OP_LOW-1:0] EX_LOGIC_NOR = 5'd3;
  localparam logic [EX_OP_LOW-1:0] EX_LOGIC_LUI = 5'd4;

  // ARITH ops
  localparam logic [EX_OP_LOW-1:0] EX_ARITH_ADD  = 5'd0;
  localparam logic [EX_OP_LOW-1:0] EX_ARITH_SUB  = 5'd1;
  localparam logic [EX_OP_LOW-1:0] EX_ARITH_SLT  = 5'd2;
  localparam logic [EX_OP_LOW-1:0] EX_ARITH_SLTU = 5'd3;

  // MEMACC ops (both produce an effective address)
  localparam logic [EX_OP_LOW-1:0] EX_MEMACC_LOAD  = 5'd0;
  localparam logic [EX_OP_LOW-1:0] EX_MEMACC_STORE = 5'd1;

  // MULDIV ops
  localparam logic [EX_OP_LOW-1:0] EX_MULDIV_MFHI  = 5'd0;
  localparam logic [EX_OP_LOW-1:0] EX_MULDIV_MFLO  = 5'd1;
  localparam logic [EX_OP_LOW-1:0] EX_MULDIV_MTHI  = 5'd2;
  localparam logic [EX_OP_LOW-1:0] EX_MULDIV_MTLO  = 5'd3;
  localparam logic [EX_OP_LOW-1:0] EX_MULDIV_MULT  = 5'd4;
  localparam logic [EX_OP_LOW-1:0] EX_MULDIV_MULTU = 5'd5;
  localparam logic [EX_OP_LOW-1:0] EX_MULDIV_DIV   = 5'd6;
  localparam logic [EX_OP_LOW-1:0] EX_MULDIV_DIVU  = 5'd7;

  // Memory op and enable encodings
  localparam logic [MEM_OP-1:0] MEM_OP_NOP   = 2'd0;
  localparam logic [MEM_OP-1:0] MEM_OP_LOAD  = 2'd1;
  localparam logic [MEM_OP-1:0] MEM_OP_STORE = 2'd2;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  // Payload handed from the ALU decode to the output forcing stage
  typedef struct packed {
    logic [WORD-1:0]   result;
    logic              we;
    logic [MEM_OP-1:0] memop;
  } alu_out_t;

  function automatic logic [WORD-1:0] neg_word(input logic [WORD-1:0] x);
    return ~x + WORD'(1);
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative 32-step multiply/divide unit and the HI/LO registers.
// Ports: clk, rst (async, active-high); start/is_signed/is_div select the op,
// op_a/op_b operands; hi_we/lo_we/wdata for MTHI/MTLO; busy_c is the
// combinational stall request, done marks the write-back cycle; hi/lo registers.
module ex_muldiv
  import ex_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_signed,
  input  logic            is_div,
  input  logic [WORD-1:0] op_a,
  input  logic [WORD-1:0] op_b,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [WORD-1:0] wdata,
  output logic            busy_c,
  output logic            done,
  output logic [WORD-1:0] hi,
  output logic [WORD-1:0] lo
);

  md_state_e         state;
  logic [CNT_W-1:0]  cnt;
  logic [2*WORD-1:0] acc;      // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [WORD-1:0]   opb_mag;  // multiplicand / divisor magnitude
  logic              div_op;
  logic              neg_lo;   // negate product or quotient in DONE
  logic              neg_hi;   // negate remainder in DONE

  logic [WORD-1:0]   a_mag, b_mag;
  logic              div_zero;
  logic [WORD:0]     step_sum, step_rem;
  logic [2*WORD-1:0] step_acc;
  logic [2*WORD-1:0] mul_fix;
  logic [WORD-1:0]   quo_fix, rem_fix;

  // Operand magnitudes, one iteration step and the DONE sign fix-ups
  always_comb begin
    a_mag    = (is_signed && op_a[WORD-1]) ? neg_word(op_a) : op_a;
    b_mag    = (is_signed && op_b[WORD-1]) ? neg_word(op_b) : op_b;
    div_zero = is_div && (op_b == '0);

    step_sum = {1'b0, acc[2*WORD-1:WORD]} + (acc[0] ? {1'b0, opb_mag} : '0);
    step_rem = {acc[2*WORD-1:WORD], acc[WORD-1]};
    if (div_op) begin
      if (step_rem >= {1'b0, opb_mag})
        step_acc = {WORD'(step_rem - {1'b0, opb_mag}), acc[WORD-2:0], 1'b1};
      else
        step_acc = {step_rem[WORD-1:0], acc[WORD-2:0], 1'b0};
    end else begin
      step_acc = {step_sum, acc[WORD-1:1]};
    end

    mul_fix = neg_lo ? (~acc + (2*WORD)'(1)) : acc;
    quo_fix = neg_lo ? neg_word(acc[WORD-1:0]) : acc[WORD-1:0];
    rem_fix = neg_hi ? neg_word(acc[2*WORD-1:WORD]) : acc[2*WORD-1:WORD];
  end

  // Stall while an op is being accepted or iterating; drops at once in reset
  assign busy_c = !rst && (((state == IDLE) && start) || (state == BUSY));
  assign done   = (state == DONE);

  // Sequencer, datapath registers and HI/LO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      opb_mag <= '0;
      div_op  <= 1'b0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            cnt    <= CNT_W'(WORD - 1);
            div_op <= is_div;
            if (div_zero) begin
              // Result preloaded so DONE writes HI=dividend, LO=all ones
              acc    <= {op_a, {WORD{1'b1}}};
              neg_lo <= 1'b0;
              neg_hi <= 1'b0;
              state  <= DONE;
            end else begin
              acc     <= {WORD'(0), a_mag};
              opb_mag <= b_mag;
              neg_lo  <= is_signed && (op_a[WORD-1] ^ op_b[WORD-1]);
              neg_hi  <= is_signed && is_div && op_a[WORD-1];
              state   <= BUSY;
            end
          end
        end
        BUSY: begin
          acc <= step_acc;
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        DONE: begin
          if (div_op) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= mul_fix[2*WORD-1:WORD];
            lo <= mul_fix[WORD-1:0];
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex.sv
// ex: execute stage. Combinational logic/arith/address ALU plus HI/LO access
// and an iterative multiply/divide unit that stalls the pipe while running.
// Ports: clk, rst (async, active-high); ex_* inputs from ID/EX; o_result,
// o_dest, o_writeEnable, o_memop to EX/MEM; stall_req to CTRL.
module ex
  import ex_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD-1:0]       ex_inst,
  input  logic [EX_OP_HIGH-1:0] ex_alusel,
  input  logic [EX_OP_LOW-1:0]  ex_aluop,
  input  logic [WORD-1:0]       ex_srcLeft,
  input  logic [WORD-1:0]       ex_srcRight,
  input  logic [MEM_OP-1:0]     ex_memop,
  input  logic [REG_ADDR-1:0]   ex_dest,
  input  logic                  ex_writeEnable,
  output logic [WORD-1:0]       o_result,
  output logic [REG_ADDR-1:0]   o_dest,
  output logic                  o_writeEnable,
  output logic [MEM_OP-1:0]     o_memop,
  output logic                  stall_req
);

  alu_out_t        alu;
  logic            def_op;
  logic            md_class;
  logic            md_we;
  logic            md_iter;
  logic            md_start, md_signed, md_div;
  logic            hi_we, lo_we;
  logic            md_busy_c, md_done;
  logic [WORD-1:0] hi, lo;
  logic            unused_inst;

  // Instruction word is carried for debug visibility only
  assign unused_inst = ^ex_inst;

  // Op decode and single-cycle ALU
  always_comb begin
    alu       = '{result: '0, we: DISABLE, memop: MEM_OP_NOP};
    def_op    = 1'b0;
    md_class  = (ex_alusel == EX_HIGH_MULDIV);
    md_we     = DISABLE;
    md_iter   = 1'b0;
    md_signed = 1'b0;
    md_div    = 1'b0;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    case (ex_alusel)
      EX_HIGH_LOGIC: begin
        def_op = 1'b1;
        case (ex_aluop)
          EX_LOGIC_AND: alu.result = ex_srcLeft & ex_srcRight;
          EX_LOGIC_OR:  alu.result = ex_srcLeft | ex_srcRight;
          EX_LOGIC_XOR: alu.result = ex_srcLeft ^ ex_srcRight;
          EX_LOGIC_NOR: alu.result = ~(ex_srcLeft | ex_srcRight);
          EX_LOGIC_LUI: alu.result = ex_srcRight << 16;
          default:      def_op = 1'b0;
        endcase
      end
      EX_HIGH_ARITH: begin
        def_op = 1'b1;
        case (ex_aluop)
          EX_ARITH_ADD:  alu.result = ex_srcLeft + ex_srcRight;
          EX_ARITH_SUB:  alu.result = ex_srcLeft - ex_srcRight;
          EX_ARITH_SLT:  alu.result = WORD'($signed(ex_srcLeft) < $signed(ex_srcRight));
          EX_ARITH_SLTU: alu.result = WORD'(ex_srcLeft < ex_srcRight);
          default:       def_op = 1'b0;
        endcase
      end
      EX_HIGH_MEMACC: begin
        if (ex_aluop == EX_MEMACC_LOAD || ex_aluop == EX_MEMACC_STORE) begin
          def_op     = 1'b1;
          alu.result = ex_srcLeft + ex_srcRight;
        end
      end
      EX_HIGH_MULDIV: begin
        def_op = 1'b1;
        case (ex_aluop)
          EX_MULDIV_MFHI:  begin alu.result = hi; md_we = ENABLE; end
          EX_MULDIV_MFLO:  begin alu.result = lo; md_we = ENABLE; end
          EX_MULDIV_MTHI:  hi_we = 1'b1;
          EX_MULDIV_MTLO:  lo_we = 1'b1;
          EX_MULDIV_MULT:  begin md_iter = 1'b1; md_signed = 1'b1; end
          EX_MULDIV_MULTU: md_iter = 1'b1;
          EX_MULDIV_DIV:   begin md_iter = 1'b1; md_signed = 1'b1; md_div = 1'b1; end
          EX_MULDIV_DIVU:  begin md_iter = 1'b1; md_div = 1'b1; end
          default:         def_op = 1'b0;
        endcase
      end
      default: def_op = 1'b0;
    endcase
    if (def_op) begin
      alu.memop = ex_memop;
      alu.we    = md_class ? md_we : ex_writeEnable;
    end
  end

  // The op whose result is being written back in DONE must not restart the unit
  assign md_start = md_iter && !md_done;

  ex_muldiv u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .start     (md_start),
    .is_signed (md_signed),
    .is_div    (md_div),
    .op_a      (ex_srcLeft),
    .op_b      (ex_srcRight),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (ex_srcLeft),
    .busy_c    (md_busy_c),
    .done      (md_done),
    .hi        (hi),
    .lo        (lo)
  );

  assign stall_req = md_busy_c;

  // Output forcing: bubbles while stalled, everything cleared in reset
  always_comb begin
    o_result      = alu.result;
    o_dest        = ex_dest;
    o_writeEnable = alu.we;
    o_memop       = alu.memop;
    if (stall_req) begin
      o_writeEnable = DISABLE;
      o_memop       = MEM_OP_NOP;
    end
    if (rst) begin
      o_result      = '0;
      o_dest        = '0;
      o_writeEnable = DISABLE;
      o_memop       = MEM_OP_NOP;
    end
  end

endmodule

// File: tb/tb_ex.sv
// tb_ex: self-checking bench for the execute stage; directed cases plus
// randomized ops checked against a plain-arithmetic reference model.
module tb_ex;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ex_inst, ex_srcLeft, ex_srcRight, o_result;
  logic [2:0]  ex_alusel;
  logic [4:0]  ex_aluop, ex_dest, o_dest;
  logic [1:0]  ex_memop, o_memop;
  logic        ex_writeEnable, o_writeEnable, stall_req;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  ex dut (
    .clk            (clk),
    .rst            (rst),
    .ex_inst        (ex_inst),
    .ex_alusel      (ex_alusel),
    .ex_aluop       (ex_aluop),
    .ex_srcLeft     (ex_srcLeft),
    .ex_srcRight    (ex_srcRight),
    .ex_memop       (ex_memop),
    .ex_dest        (ex_dest),
    .ex_writeEnable (ex_writeEnable),
    .o_result       (o_result),
    .o_dest         (o_dest),
    .o_writeEnable  (o_writeEnable),
    .o_memop        (o_memop),
    .stall_req      (stall_req)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [2:0] sel, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] mop, input logic we);
    ex_alusel      = sel;
    ex_aluop       = op;
    ex_srcLeft     = a;
    ex_srcRight    = b;
    ex_memop       = mop;
    ex_writeEnable = we;
    ex_dest        = 5'($urandom);
    ex_inst        = $urandom;
  endtask

  // Expected {HI,LO} of an iterative op from ordinary integer arithmetic
  function automatic logic [63:0] md_model(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 64'd0;
    case (op)
      EX_MULDIV_MULT:  r = 64'(sa * sb);
      EX_MULDIV_MULTU: r = {32'd0, a} * {32'd0, b};
      EX_MULDIV_DIV:   if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                       else r = {32'(sa % sb), 32'(sa / sb)};
      EX_MULDIV_DIVU:  if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                       else r = {a % b, a / b};
      default:         r = 64'd0;
    endcase
    return r;
  endfunction

  // One single-cycle op: called at posedge+1, returns at the next posedge+1
  task automatic single(input string tag, input logic [2:0] sel, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [1:0] mop,
                        input logic we);
    logic [31:0] er;
    logic        ewe;
    logic [1:0]  emop;
    logic        known;
    logic        set_hi, set_lo;
    er = 32'd0; ewe = 1'b0; emop = MEM_OP_NOP; known = 1'b1; set_hi = 1'b0; set_lo = 1'b0;
    apply(sel, op, a, b, mop, we);
    case (sel)
      EX_HIGH_LOGIC: begin
        ewe = we;
        case (op)
          EX_LOGIC_AND: er = a & b;
          EX_LOGIC_OR:  er = a | b;
          EX_LOGIC_XOR: er = a ^ b;
          EX_LOGIC_NOR: er = ~(a | b);
          EX_LOGIC_LUI: er = {b[15:0], 16'h0000};
          default:      known = 1'b0;
        endcase
      end
      EX_HIGH_ARITH: begin
        ewe = we;
        case (op)
          EX_ARITH_ADD:  er = a + b;
          EX_ARITH_SUB:  er = a - b;
          EX_ARITH_SLT:  er = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          EX_ARITH_SLTU: er = (a < b) ? 32'd1 : 32'd0;
          default:       known = 1'b0;
        endcase
      end
      EX_HIGH_MEMACC: begin
        ewe = we;
        if (op == EX_MEMACC_LOAD || op == EX_MEMACC_STORE) er = a + b;
        else known = 1'b0;
      end
      EX_HIGH_MULDIV: begin
        case (op)
          EX_MULDIV_MFHI: begin er = m_hi; ewe = 1'b1; end
          EX_MULDIV_MFLO: begin er = m_lo; ewe = 1'b1; end
          EX_MULDIV_MTHI: set_hi = 1'b1;
          EX_MULDIV_MTLO: set_lo = 1'b1;
          default:        known = 1'b0;
        endcase
      end
      default: known = 1'b0;
    endcase
    if (known) emop = mop;
    else begin er = 32'd0; ewe = 1'b0; end
    @(negedge clk);
    check({tag, "/result"}, o_result, er);
    check({tag, "/we"}, 32'(o_writeEnable), 32'(ewe));
    check({tag, "/memop"}, 32'(o_memop), 32'(emop));
    check({tag, "/dest"}, 32'(o_dest), 32'(ex_dest));
    check({tag, "/stall"}, 32'(stall_req), 32'd0);
    @(posedge clk);
    if (set_hi) m_hi = a;
    if (set_lo) m_lo = a;
    #1;
  endtask

  // One iterative op, then MFHI and MFLO read-back
  task automatic iter(input string tag, input logic [4:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    int n;
    int exp_n;
    logic [63:0] e64;
    apply(EX_HIGH_MULDIV, op, a, b, MEM_OP_LOAD, 1'b1);
    e64   = md_model(op, a, b);
    exp_n = ((op == EX_MULDIV_DIV || op == EX_MULDIV_DIVU) && b == 32'd0) ? 1 : 33;
    n = 0;
    @(negedge clk);
    check({tag, "/bubble_memop"}, 32'(o_memop), 32'(MEM_OP_NOP));
    while (stall_req === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({tag, "/stall_cycles"}, 32'(n), 32'(exp_n));
    @(posedge clk);
    #1;
    m_hi = e64[63:32];
    m_lo = e64[31:0];
    single({tag, "/mfhi"}, EX_HIGH_MULDIV, EX_MULDIV_MFHI, 32'd0, 32'd0, MEM_OP_NOP, 1'b0);
    single({tag, "/mflo"}, EX_HIGH_MULDIV, EX_MULDIV_MFLO, 32'd0, 32'd0, MEM_OP_NOP, 1'b0);
  endtask

  initial begin
    logic [2:0]  rsel;
    logic [4:0]  rop;
    logic [31:0] ra, rb;

    // Reset state with a live instruction on the inputs
    rst = 1'b1;
    apply(EX_HIGH_ARITH, EX_ARITH_ADD, 32'd1, 32'd2, MEM_OP_LOAD, 1'b1);
    @(negedge clk);
    check("rst/result", o_result, 32'd0);
    check("rst/we", 32'(o_writeEnable), 32'd0);
    check("rst/memop", 32'(o_memop), 32'(MEM_OP_NOP));
    check("rst/dest", 32'(o_dest), 32'd0);
    check("rst/stall", 32'(stall_req), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed single-cycle cases
    single("add_wrap", EX_HIGH_ARITH, EX_ARITH_ADD, 32'h7FFF_FFFF, 32'd1, MEM_OP_NOP, 1'b1);
    single("sub_wrap", EX_HIGH_ARITH, EX_ARITH_SUB, 32'd0, 32'd1, MEM_OP_NOP, 1'b1);
    single("slt", EX_HIGH_ARITH, EX_ARITH_SLT, 32'hFFFF_FFFF, 32'd1, MEM_OP_NOP, 1'b1);
    single("sltu", EX_HIGH_ARITH, EX_ARITH_SLTU, 32'hFFFF_FFFF, 32'd1, MEM_OP_NOP, 1'b1);
    single("lui", EX_HIGH_LOGIC, EX_LOGIC_LUI, 32'd0, 32'h0000_ABCD, MEM_OP_NOP, 1'b1);
    single("nor", EX_HIGH_LOGIC, EX_LOGIC_NOR, 32'h0F0F_0000, 32'h0000_00FF, MEM_OP_NOP, 1'b1);
    single("memacc", EX_HIGH_MEMACC, EX_MEMACC_STORE, 32'h0000_1000, 32'hFFFF_FFFC,
           MEM_OP_STORE, 1'b0);
    single("special", EX_HIGH_SPECIAL, 5'd3, 32'h1234, 32'h5678, MEM_OP_LOAD, 1'b1);
    single("undef_logic", EX_HIGH_LOGIC, 5'd9, 32'h1234, 32'h5678, MEM_OP_LOAD, 1'b1);

    // HI/LO moves
    single("mthi", EX_HIGH_MULDIV, EX_MULDIV_MTHI, 32'h0000_1234, 32'd0, MEM_OP_NOP, 1'b1);
    single("mfhi_after_mthi", EX_HIGH_MULDIV, EX_MULDIV_MFHI, 32'd0, 32'd0, MEM_OP_NOP, 1'b0);
    single("mtlo", EX_HIGH_MULDIV, EX_MULDIV_MTLO, 32'hCAFE_0001, 32'd0, MEM_OP_NOP, 1'b1);
    single("mflo_after_mtlo", EX_HIGH_MULDIV, EX_MULDIV_MFLO, 32'd0, 32'd0, MEM_OP_NOP, 1'b0);

    // Directed iterative cases
    iter("mult_neg", EX_MULDIV_MULT, 32'hFFFF_FFFD, 32'd7);
    iter("div_neg", EX_MULDIV_DIV, 32'hFFFF_FFF9, 32'd2);
    iter("divu_zero", EX_MULDIV_DIVU, 32'd7, 32'd0);
    iter("div_zero_signed", EX_MULDIV_DIV, 32'h8000_0005, 32'd0);
    iter("div_neg_divisor", EX_MULDIV_DIV, 32'd100, 32'hFFFF_FFF9);

    // Reset in the middle of BUSY
    apply(EX_HIGH_MULDIV, EX_MULDIV_MULT, 32'd5, 32'd9, MEM_OP_NOP, 1'b0);
    @(negedge clk);
    repeat (10) @(negedge clk);
    check("midbusy/stall_before", 32'(stall_req), 32'd1);
    rst = 1'b1;
    #1;
    check("midbusy/stall_in_rst", 32'(stall_req), 32'd0);
    check("midbusy/result_in_rst", o_result, 32'd0);
    apply(EX_HIGH_MULDIV, EX_MULDIV_MFHI, 32'd0, 32'd0, MEM_OP_NOP, 1'b0);
    #1;
    check("midbusy/we_in_rst", 32'(o_writeEnable), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(posedge clk);
    #1;
    single("post_rst_mfhi", EX_HIGH_MULDIV, EX_MULDIV_MFHI, 32'd0, 32'd0, MEM_OP_NOP, 1'b0);
    single("post_rst_mflo", EX_HIGH_MULDIV, EX_MULDIV_MFLO, 32'd0, 32'd0, MEM_OP_NOP, 1'b0);
    iter("multu_max", EX_MULDIV_MULTU, 32'hFFFF_FFFF, 32'd2);

    // Randomized mix against the reference model
    for (int i = 0; i < 80; i++) begin
      rsel = 3'($urandom_range(0, 4));
      rop  = 5'($urandom_range(0, 7));
      ra   = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed(32'($urandom_range(0, 40)) - 32'd20));
      rb   = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed(32'($urandom_range(0, 40)) - 32'd20));
      if (rsel == EX_HIGH_MULDIV && rop >= EX_MULDIV_MULT) begin
        if (rop >= EX_MULDIV_DIV && $urandom_range(0, 3) == 0) rb = 32'd0;
        iter("rand_iter", rop, ra, rb);
      end else begin
        single("rand_single", rsel, rop, ra, rb, 2'($urandom_range(0, 2)), 1'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
